// File: rtl/edge_level_gen_pkg.sv
// edge_level_gen_pkg: shared state encoding and hold reload helper for edge_level_gen
package edge_level_gen_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    HOLD_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    HOLD_LOW  = 2'd3
  } state_t;
  typedef enum logic {DIR_LOW = 1'b0, DIR_HIGH = 1'b1} dir_t;
  function automatic int unsigned reload_val(input dir_t dir, input int unsigned min_high,
                                             input int unsigned min_low);
    return (dir == DIR_HIGH ? min_high : min_low) - 1;
  endfunction
endpackage

// File: rtl/edge_level_gen_min_width_counter.sv
// min_width_counter: load/decrement hold counter with a zero flag
module min_width_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load_i) cnt <= val_i;
    else if (dec_i && cnt != '0) cnt <= cnt - 1'b1;
  assign zero_o = cnt == '0;
endmodule

// File: rtl/edge_level_gen.sv
// edge_level_gen: turns rise/fall request strobes into a level with minimum high/low widths
module edge_level_gen
  import edge_level_gen_pkg::*;
#(
  parameter int unsigned MIN_HIGH = 3,
  parameter int unsigned MIN_LOW  = 3,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rise_req_i,
  input  logic fall_req_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o,
  output logic drop_o
);
  state_t state, state_n;
  dir_t load_dir;
  logic pend, pend_n, load, dec, zero, drop_n, rise_n, fall_n, r, f, both;
  assign both = rise_req_i & fall_req_i;
  assign r = rise_req_i & ~fall_req_i;
  assign f = fall_req_i & ~rise_req_i;
  min_width_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .load_i(load),
    .dec_i(dec),
    .val_i(CNT_W'(reload_val(load_dir, MIN_HIGH, MIN_LOW))),
    .zero_o(zero)
  );
  always_comb begin
    state_n = state;
    pend_n = pend;
    load = 1'b0;
    load_dir = DIR_LOW;
    dec = 1'b0;
    drop_n = both;
    rise_n = 1'b0;
    fall_n = 1'b0;
    unique case (state)
      IDLE_LOW: if (r) begin
        state_n = HOLD_HIGH;
        load = 1'b1;
        load_dir = DIR_HIGH;
        rise_n = 1'b1;
      end
      IDLE_HIGH: if (f) begin
        state_n = HOLD_LOW;
        load = 1'b1;
        fall_n = 1'b1;
      end
      HOLD_HIGH:
        if (!zero) begin
          dec = 1'b1;
          if (f) begin
            drop_n = pend;
            pend_n = 1'b1;
          end else if (r) pend_n = 1'b0;
        end else if (pend || f) begin
          state_n = HOLD_LOW;
          load = 1'b1;
          fall_n = 1'b1;
          pend_n = 1'b0;
        end else state_n = IDLE_HIGH;
      HOLD_LOW:
        if (!zero) begin
          dec = 1'b1;
          if (r) begin
            drop_n = pend;
            pend_n = 1'b1;
          end else if (f) pend_n = 1'b0;
        end else if (pend || r) begin
          state_n = HOLD_HIGH;
          load = 1'b1;
          load_dir = DIR_HIGH;
          rise_n = 1'b1;
          pend_n = 1'b0;
        end else state_n = IDLE_LOW;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE_LOW;
      pend <= 1'b0;
      level_o <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      busy_o <= 1'b0;
      drop_o <= 1'b0;
    end else begin
      state <= state_n;
      pend <= pend_n;
      level_o <= state_n == HOLD_HIGH || state_n == IDLE_HIGH;
      rise_o <= rise_n;
      fall_o <= fall_n;
      busy_o <= state_n == HOLD_HIGH || state_n == HOLD_LOW;
      drop_o <= drop_n;
    end
endmodule

// File: tb/tb_edge_level_gen.sv
// tb_edge_level_gen: directed vectors checking {level,rise,fall,busy,drop} after each edge
module tb_edge_level_gen;
  logic clk = 1'b0, reset = 1'b1, rise_req_i = 1'b0, fall_req_i = 1'b0;
  logic level_o, rise_o, fall_o, busy_o, drop_o;
  int tests = 0, fails = 0;
  edge_level_gen dut (
    .clk(clk),
    .reset(reset),
    .rise_req_i(rise_req_i),
    .fall_req_i(fall_req_i),
    .level_o(level_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .busy_o(busy_o),
    .drop_o(drop_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: lrfbd got %b want %b", tag, got, exp);
    end
  endtask
  task automatic tick(input logic r, input logic f, input string tag, input logic [4:0] exp);
    rise_req_i = r;
    fall_req_i = f;
    @(posedge clk);
    #1;
    check(tag, {level_o, rise_o, fall_o, busy_o, drop_o}, exp);
  endtask
  initial begin
    tick(0, 0, "reset0", 5'b00000);
    tick(0, 0, "reset1", 5'b00000);
    reset = 1'b0;
    tick(1, 0, "rise", 5'b11010);
    tick(0, 0, "hold_h1", 5'b10010);
    tick(0, 0, "hold_h2", 5'b10010);
    tick(0, 0, "idle_h", 5'b10000);
    tick(1, 0, "same_dir_idle", 5'b10000);
    tick(0, 1, "fall", 5'b00110);
    tick(1, 0, "pend_rise", 5'b00010);
    tick(0, 0, "hold_l2", 5'b00010);
    tick(0, 0, "pend_take_rise", 5'b11010);
    tick(0, 1, "pend_fall", 5'b10010);
    tick(0, 1, "drop_second", 5'b10011);
    tick(0, 0, "pend_take_fall", 5'b00110);
    tick(0, 0, "hold_l_a", 5'b00010);
    tick(0, 0, "hold_l_b", 5'b00010);
    tick(0, 0, "idle_l", 5'b00000);
    tick(1, 1, "both_drop", 5'b00001);
    tick(1, 0, "rise2", 5'b11010);
    tick(0, 1, "pend_before_rst", 5'b10010);
    reset = 1'b1;
    tick(1, 0, "reset_mid", 5'b00000);
    reset = 1'b0;
    tick(0, 0, "pend_lost", 5'b00000);
    tick(1, 0, "fresh_rise", 5'b11010);
    tick(0, 0, "fresh_h1", 5'b10010);
    tick(0, 0, "fresh_h2", 5'b10010);
    tick(0, 0, "fresh_idle", 5'b10000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/edge_level_gen.md
# edge_level_gen

Edge-request-to-level waveform generator: the driving end of the single-bit edge detector. Accepts one-cycle rise/fall request strobes and drives a registered level with guaranteed minimum high and low widths. Also emits edge strobes aligned with each level change. Sits in front of any edge-detect consumer as a stimulus/handshake source.

## Interface
- `MIN_HIGH`, 3: minimum cycles `level_o` stays 1 after a rising transition (≥1).
- `MIN_LOW`, 3: minimum cycles `level_o` stays 0 after a falling transition (≥1).
- `CNT_W`, 4: hold-counter width; MIN_HIGH-1 and MIN_LOW-1 must fit.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `rise_req_i` in 1: one-cycle request to drive the level high.
- `fall_req_i` in 1: one-cycle request to drive the level low.
- `level_o` out 1: registered output level.
- `rise_o` out 1: one-cycle strobe in the first cycle `level_o` is 1.
- `fall_o` out 1: one-cycle strobe in the first cycle `level_o` is 0.
- `busy_o` out 1: 1 while a minimum-width hold is in progress.
- `drop_o` out 1: one-cycle strobe when a request is discarded.

## Operation
- States: IDLE_LOW, HOLD_HIGH, IDLE_HIGH, HOLD_LOW. Reset → IDLE_LOW; all outputs 0, counter 0, pending flag 0.
- IDLE_LOW + rise_req_i: level_o←1, rise_o←1, cnt←MIN_HIGH-1, → HOLD_HIGH.
- IDLE_HIGH + fall_req_i: level_o←0, fall_o←1, cnt←MIN_LOW-1, → HOLD_LOW.
- HOLD_x, cnt≠0: cnt decrements. An opposite request sets a one-deep pending flag. A same-direction request clears pending. Neither case drops.
- HOLD_x, cnt==0: if pending or an opposite request is present this cycle, take the opposite transition immediately (reload cnt, enter opposite HOLD, clear pending). Otherwise go to IDLE_x.
- Same-direction request in IDLE (e.g. rise_req_i in IDLE_HIGH): ignored, no drop.
- Opposite request in HOLD_x while pending already set: drop_o pulses; pending stays set.
- rise_req_i and fall_req_i both high in the same cycle, in any state: both discarded, drop_o pulses, and state, pending and cnt advance as if no request was present.
- busy_o = state ∈ {HOLD_HIGH, HOLD_LOW}, registered with the state.
- Reset mid-hold: the next cycle is in IDLE_LOW with level_o 0. No fall_o strobe is generated, pending is discarded, and requests in the reset cycle are ignored.

## Timing
- Request sampled at edge n → level_o, rise_o/fall_o, busy_o update after edge n (1-cycle latency).
- High width ≥ MIN_HIGH cycles and low width ≥ MIN_LOW cycles after any transition. Both are exact when the opposite request is pending.
- With pending set, the transition occurs after the edge at which cnt==0, i.e. MIN_x cycles after entering HOLD_x.
- rise_o/fall_o never both 1. rise_o is never 1 when level_o was 1 in the prior cycle.
- drop_o is asserted in the cycle after the offending request.

## Structure
- Shared package: the state enum (2-bit, IDLE_LOW=0, HOLD_HIGH=1, IDLE_HIGH=2, HOLD_LOW=3) and a function returning the reload value for a direction.
- One sub-module, `min_width_counter`: a CNT_W-bit load/decrement counter with a `zero_o` flag. The FSM, pending flag and output registers stay in the top module.

## Test plan
- Reset, then rise_req_i at cycle 2 → level_o=1 and rise_o=1 from cycle 3. busy_o=1 for cycles 3–5, 0 at cycle 6 (MIN_HIGH=3).
- High, IDLE_HIGH, fall_req_i one cycle → level_o=0 and fall_o=1 the next cycle. Low held ≥3 cycles.
- rise_req_i at cycle 2, fall_req_i at cycle 3 (inside hold) → level_o falls exactly at cycle 6, fall_o=1 at cycle 6, drop_o stays 0.
- Within HOLD_HIGH with fall pending, a second fall_req_i → drop_o=1 one cycle. The level still falls once, at cnt==0.
- rise_req_i and fall_req_i both high in IDLE_LOW → drop_o=1 next cycle, level_o stays 0, no strobes.
- reset asserted at cycle 4 during HOLD_HIGH → at cycle 5 level_o=0, busy_o=0, fall_o=0. A pending fall is lost, and rise_req_i at cycle 6 starts a fresh hold.
